fifo2_sync: RTL

//  Single-clock, parametrised successor FIFO for same-domain buffering; no CDC synchronisers.

---
 rtl/fifo2_pkg.sv | 23 ++
 rtl/fifo2_mem.sv | 30 +++
 rtl/fifo2_sync.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fifo2_pkg.sv
// fifo2_pkg: shared sizing helpers and default widths for the fifo2_sync FIFO.
// Optional feature macro used by fifo2_sync: FIFO2_FWFT_EN (first-word-fall-through read).
package fifo2_pkg;

    // Default configuration, also used by the testbench to size its signals.
    localparam int DEF_DSIZE = 8;
    localparam int DEF_ASIZE = 4;
    localparam int PTR_W     = DEF_ASIZE + 1;
    localparam int CNT_W     = DEF_ASIZE + 1;

    // Number of entries for a given address width.
    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    // Almost-full must lie in 1..DEPTH and almost-empty in 0..DEPTH-1.
    function automatic bit thresholds_ok(input int asize, input int afullTh, input int aemptyTh);
        int depth;
        depth = fifo_depth(asize);
        return (afullTh >= 1) && (afullTh <= depth) && (aemptyTh >= 0) && (aemptyTh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo2_mem.sv
// fifo2_mem: DEPTH x DSIZE register array, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo2_mem
    import fifo2_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             wclken,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem [DEPTH];

    // Store the incoming word only when the owner has accepted the write.
    always_ff @(posedge clk) begin
        if (wclken) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo2_sync.sv
// fifo2_sync: single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
// Define FIFO2_FWFT_EN for first-word-fall-through reads; the default build
// has a registered read port with a one-cycle rvalid pulse.
module fifo2_sync
    import fifo2_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic             flush,
    input  logic             clr_err,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = fifo_depth(ASIZE);
    localparam int PW    = ASIZE + 1;

    if (!thresholds_ok(ASIZE, AFULL_TH, AEMPTY_TH)) begin : gThresholdCheck
        $error("fifo2_sync: AFULL_TH must be 1..DEPTH and AEMPTY_TH 0..DEPTH-1");
    end

    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wrAccept, rdAccept;
    logic [DSIZE-1:0] memRdata;

    // Flags are pure decodes of the registered count, so they trail the edge by one cycle.
    assign wfull         = (count_q == PW'(DEPTH));
    assign rempty        = (count_q == '0);
    assign walmost_full  = (count_q >= PW'(AFULL_TH));
    assign ralmost_empty = (count_q <= PW'(AEMPTY_TH));
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

    // Flush has priority over both ports; full/empty are the pre-edge values.
    assign wrAccept = winc && !wfull && !flush;
    assign rdAccept = rinc && !rempty && !flush;

    fifo2_mem #(
        .DSIZE(DSIZE),
        .ASIZE(ASIZE)
    ) uMem (
        .clk   (clk),
        .wclken(wrAccept),
        .waddr (wrPtr_q[ASIZE-1:0]),
        .wdata (wdata),
        .raddr (rdPtr_q[ASIZE-1:0]),
        .rdata (memRdata)
    );

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        overflow_d  = (overflow_q && !clr_err) || (winc && wfull && !flush);
        underflow_d = (underflow_q && !clr_err) || (rinc && rempty && !flush);
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (wrAccept) wrPtr_d = wrPtr_q + PW'(1);
            if (rdAccept) rdPtr_d = rdPtr_q + PW'(1);
            case ({wrAccept, rdAccept})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Register pointer, count and error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef FIFO2_FWFT_EN
    // Head word is presented directly from the array whenever the FIFO holds data.
    assign rdata  = memRdata;
    assign rvalid = !rempty;
`else
    logic [DSIZE-1:0] rdData_q;
    logic             rdValid_q;

    // Capture the head word on an accepted pop; rvalid pulses for that one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
        end else begin
            rdValid_q <= rdAccept;
            if (rdAccept) begin
                rdData_q <= memRdata;
            end
        end
    end

    assign rdata  = rdData_q;
    assign rvalid = rdValid_q;
`endif

endmodule
